// File: rtl/piradip_barrel_shifter.sv
// Pipelined AXI-stream barrel shifter (LSL/LSR/ASR/ROL), one mux stage per shift bit.
// Define PIRADIP_SHIFTER_SKID_EN to add a 2-entry input skid buffer with a registered s_axis_tready.
`timescale 1ns/1ps

module piradip_barrel_shifter #(
  parameter int DATA_WIDTH     = 32,
  parameter int SHIFT_WIDTH    = $clog2(DATA_WIDTH) + 1,
  parameter int STAGES_PER_REG = 1,
  parameter int USER_WIDTH     = 1
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [SHIFT_WIDTH-1:0] s_axis_tshift,
  input  logic [1:0]             s_axis_tmode,
  input  logic [USER_WIDTH-1:0]  s_axis_tuser,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [USER_WIDTH-1:0]  m_axis_tuser,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready
);

  typedef enum logic [1:0] {
    MODE_LSL = 2'b00,
    MODE_LSR = 2'b01,
    MODE_ASR = 2'b10,
    MODE_ROL = 2'b11
  } mode_e;

  // Everything a beat needs travels together; sign is the original operand MSB used for ASR fill.
  typedef struct packed {
    logic [DATA_WIDTH-1:0]  data;
    logic [SHIFT_WIDTH-1:0] shift;
    mode_e                  mode;
    logic                   sign;
    logic [USER_WIDTH-1:0]  user;
    logic                   last;
  } beat_t;

  localparam int SPR_SAFE = (STAGES_PER_REG == 0) ? 1 : STAGES_PER_REG;

  if (DATA_WIDTH < 2 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a power of two >= 2");
  end
  if (SHIFT_WIDTH < 1 || SHIFT_WIDTH > 30) begin : g_bad_shift
    $error("SHIFT_WIDTH out of range");
  end
  if (STAGES_PER_REG < 0) begin : g_bad_spr
    $error("STAGES_PER_REG must be >= 0");
  end

  beat_t in_beat;
  beat_t head_beat;
  logic  head_valid;
  logic  head_ready;

  assign in_beat = '{
    data:  s_axis_tdata,
    shift: s_axis_tshift,
    mode:  mode_e'(s_axis_tmode),
    sign:  s_axis_tdata[DATA_WIDTH-1],
    user:  s_axis_tuser,
    last:  s_axis_tlast
  };

`ifdef PIRADIP_SHIFTER_SKID_EN
  beat_t      skid_mem [2];
  logic [1:0] skid_cnt;
  logic [1:0] skid_cnt_nxt;
  logic       skid_wr;
  logic       skid_rd;
  logic       skid_ready_q;
  logic       skid_push;
  logic       skid_pop;

  assign skid_push    = s_axis_tvalid & skid_ready_q;
  assign skid_pop     = head_valid & head_ready;
  assign skid_cnt_nxt = skid_cnt + {1'b0, skid_push} - {1'b0, skid_pop};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      // NOTE: the skid entries are cleared on reset as well, so a discarded beat can never resurface.
      skid_mem[0]  <= '0;
      skid_mem[1]  <= '0;
      skid_cnt     <= '0;
      skid_wr      <= 1'b0;
      skid_rd      <= 1'b0;
      skid_ready_q <= 1'b0;
    end else begin
      if (skid_push) begin
        skid_mem[skid_wr] <= in_beat;
        skid_wr           <= ~skid_wr;
      end
      if (skid_pop) begin
        skid_rd <= ~skid_rd;
      end
      skid_cnt     <= skid_cnt_nxt;
      // Ready looks one beat ahead so it can come straight from a flop.
      skid_ready_q <= (skid_cnt_nxt != 2'd2);
    end
  end

  assign head_beat     = skid_mem[skid_rd];
  assign head_valid    = (skid_cnt != 2'd0);
  assign s_axis_tready = skid_ready_q;
`else
  assign head_beat     = in_beat;
  assign head_valid    = s_axis_tvalid;
  assign s_axis_tready = head_ready & aresetn;
`endif

  for (genvar i = 0; i < SHIFT_WIDTH; i++) begin : g_stage
    localparam int DIST   = 1 << i;
    localparam bit IS_REG = (STAGES_PER_REG != 0) &&
                            ((((i + 1) % SPR_SAFE) == 0) || (i == SHIFT_WIDTH - 1));

    beat_t stage_in;
    beat_t mux_beat;
    beat_t out_beat;
    logic  in_valid;
    logic  in_ready;
    logic  out_valid;
    logic  out_ready;

    if (i == 0) begin : g_first
      assign stage_in = head_beat;
      assign in_valid = head_valid;
    end else begin : g_chain
      assign stage_in = g_stage[i-1].out_beat;
      assign in_valid = g_stage[i-1].out_valid;
    end

    if (i == SHIFT_WIDTH - 1) begin : g_last
      assign out_ready = m_axis_tready;
    end else begin : g_mid
      assign out_ready = g_stage[i+1].in_ready;
    end

    if (DIST >= DATA_WIDTH) begin : g_sat
      // Distances at or beyond the word width saturate; rotate wraps, so it is a no-op here.
      always_comb begin
        // NOTE: default the whole output first so no path through the case leaves it unassigned (no latch).
        mux_beat = stage_in;
        if (stage_in.shift[i]) begin
          case (stage_in.mode)
            MODE_LSL, MODE_LSR: mux_beat.data = '0;
            MODE_ASR:           mux_beat.data = {DATA_WIDTH{stage_in.sign}};
            default:            mux_beat.data = stage_in.data;
          endcase
        end
      end
    end else begin : g_shift
      always_comb begin
        mux_beat = stage_in;
        if (stage_in.shift[i]) begin
          case (stage_in.mode)
            MODE_LSL: mux_beat.data = {stage_in.data[DATA_WIDTH-1-DIST:0], {DIST{1'b0}}};
            MODE_LSR: mux_beat.data = {{DIST{1'b0}}, stage_in.data[DATA_WIDTH-1:DIST]};
            MODE_ASR: mux_beat.data = {{DIST{stage_in.sign}}, stage_in.data[DATA_WIDTH-1:DIST]};
            default:  mux_beat.data = {stage_in.data[DATA_WIDTH-1-DIST:0],
                                       stage_in.data[DATA_WIDTH-1:DATA_WIDTH-DIST]};
          endcase
        end
      end
    end

    if (IS_REG) begin : g_reg
      beat_t beat_q;
      logic  valid_q;

      // A full stage still accepts when its contents leave in the same cycle.
      assign in_ready = ~valid_q | out_ready;

      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          valid_q <= 1'b0;
          beat_q  <= '0;
        end else begin
          // NOTE: state is updated with non-blocking assignments so every stage samples pre-edge values.
          if (in_ready) begin
            valid_q <= in_valid;
          end
          if (in_valid && in_ready) begin
            beat_q <= mux_beat;
          end
        end
      end

      assign out_beat  = beat_q;
      assign out_valid = valid_q;
    end else begin : g_comb
      assign in_ready  = out_ready;
      assign out_beat  = mux_beat;
      assign out_valid = in_valid;
    end
  end

  beat_t tail;
  logic  unused_tail;

  assign head_ready    = g_stage[0].in_ready;
  assign tail          = g_stage[SHIFT_WIDTH-1].out_beat;
  assign m_axis_tdata  = tail.data;
  assign m_axis_tuser  = tail.user;
  assign m_axis_tlast  = tail.last;
  assign m_axis_tvalid = g_stage[SHIFT_WIDTH-1].out_valid & aresetn;
  assign unused_tail   = ^{tail.shift, tail.mode, tail.sign};

endmodule

// File: tb/tb_piradip_barrel_shifter.sv
// Directed self-checking bench for piradip_barrel_shifter (STAGES_PER_REG = 1, 0 and 3 instances).
`timescale 1ns/1ps

module tb_piradip_barrel_shifter;

`ifdef PIRADIP_SHIFTER_SKID_EN
  localparam int SKID = 1;
`else
  localparam int SKID = 0;
`endif
  localparam int L1 = 6 + SKID;
  localparam int L0 = 0 + SKID;
  localparam int L3 = 2 + SKID;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] s_tdata;
  logic [5:0]  s_tshift;
  logic [1:0]  s_tmode;
  logic [1:0]  s_tuser;
  logic        s_tlast;
  logic        s_valid, s_ready, a_valid, a_ready;
  logic [31:0] m_data, md0, md3;
  logic [1:0]  m_user, mu0, mu3;
  logic        m_last, ml0, ml3;
  logic        m_valid, mv0, mv3;
  logic        m_ready, r0, r3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 aclk = ~aclk;

  piradip_barrel_shifter #(.DATA_WIDTH(32), .STAGES_PER_REG(1), .USER_WIDTH(2)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tshift(s_tshift), .s_axis_tmode(s_tmode),
    .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast), .s_axis_tvalid(s_valid),
    .s_axis_tready(s_ready),
    .m_axis_tdata(m_data), .m_axis_tuser(m_user), .m_axis_tlast(m_last),
    .m_axis_tvalid(m_valid), .m_axis_tready(m_ready));

  piradip_barrel_shifter #(.DATA_WIDTH(32), .STAGES_PER_REG(0), .USER_WIDTH(2)) dut0 (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tshift(s_tshift), .s_axis_tmode(s_tmode),
    .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast), .s_axis_tvalid(a_valid),
    .s_axis_tready(r0),
    .m_axis_tdata(md0), .m_axis_tuser(mu0), .m_axis_tlast(ml0),
    .m_axis_tvalid(mv0), .m_axis_tready(a_ready));

  piradip_barrel_shifter #(.DATA_WIDTH(32), .STAGES_PER_REG(3), .USER_WIDTH(2)) dut3 (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tshift(s_tshift), .s_axis_tmode(s_tmode),
    .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast), .s_axis_tvalid(a_valid),
    .s_axis_tready(r3),
    .m_axis_tdata(md3), .m_axis_tuser(mu3), .m_axis_tlast(ml3),
    .m_axis_tvalid(mv3), .m_axis_tready(a_ready));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [5:0] s,
                                            input logic [1:0] m);
    logic [63:0] dd;
    case (m)
      2'd0:    return (s >= 6'd32) ? 32'h0 : d << s;
      2'd1:    return (s >= 6'd32) ? 32'h0 : d >> s;
      2'd2:    return (s >= 6'd32) ? {32{d[31]}} : 32'($signed(d) >>> s);
      default: begin
        dd = {d, d} << s[4:0];
        return dd[63:32];
      end
    endcase
  endfunction

  // Present one beat on the main instance and wait (bounded) for its handshake.
  task automatic push_beat(input logic [31:0] d, input logic [5:0] s, input logic [1:0] m,
                           input logic [1:0] u, input logic l);
    bit done = 1'b0;
    s_tdata = d; s_tshift = s; s_tmode = m; s_tuser = u; s_tlast = l; s_valid = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge aclk);
      if (s_ready) done = 1'b1;
      @(posedge aclk); #1;
    end
    s_valid = 1'b0;
    check("push_handshake", 32'(done), 32'd1);
  endtask

  // Wait (bounded) for the next output with m_ready high; cyc counts edges from the input handshake.
  task automatic pull_beat(output logic [31:0] d, output logic [1:0] u, output logic l,
                           output int cyc);
    cyc = 1;
    while (!m_valid && cyc < 64) begin
      @(posedge aclk); #1;
      cyc++;
    end
    d = m_data; u = m_user; l = m_last;
    @(posedge aclk); #1;
  endtask

  task automatic do_vec(input string tag, input logic [31:0] d, input logic [5:0] s,
                        input logic [1:0] m, input logic [31:0] exp);
    logic [31:0] rd; logic [1:0] ru; logic rl; int cyc;
    push_beat(d, s, m, 2'd0, 1'b0);
    pull_beat(rd, ru, rl, cyc);
    check(tag, rd, exp);
  endtask

  logic [31:0] vd;
  logic [1:0]  vu;
  logic        vl;
  int          lat;
  logic [31:0] rnd_d [64];
  logic [5:0]  rnd_s [64];
  logic [1:0]  rnd_m [64];
  logic [1:0]  rnd_u [64];
  logic        rnd_l [64];
  logic [31:0] rnd_e [64];
  logic [31:0] tp_e  [100];
  int rcv, stall_err, extra, stale;
  int sent, rcv1, rcv0, rcv3, done1, done0, done3;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b1;
    s_tdata = '0; s_tshift = '0; s_tmode = '0; s_tuser = '0; s_tlast = 1'b0;
    s_valid = 1'b0; a_valid = 1'b0; m_ready = 1'b0; a_ready = 1'b1;
    #1 aresetn = 1'b0;
    #1;
    check("reset_s_ready", 32'(s_ready), 32'd0);
    check("reset_m_valid", 32'(m_valid), 32'd0);
    check("reset_m_data", m_data, 32'h0);
    check("reset_mv0", 32'(mv0), 32'd0);
    check("reset_r0", 32'(r0), 32'd0);
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk); #1;
    check("release_s_ready", 32'(s_ready), 32'd1);
    check("release_m_valid", 32'(m_valid), 32'd0);
    m_ready = 1'b1;

    // Directed vectors with hand-computed results.
    push_beat(32'h0000_0001, 6'd5, 2'd0, 2'd2, 1'b1);
    pull_beat(vd, vu, vl, lat);
    check("lsl_5_latency", 32'(lat), 32'(L1));
    check("lsl_5", vd, 32'h0000_0020);
    check("lsl_5_user", 32'(vu), 32'd2);
    check("lsl_5_last", 32'(vl), 32'd1);
    do_vec("lsl_40", 32'h0000_0001, 6'd40, 2'd0, 32'h0000_0000);
    do_vec("lsl_0", 32'hDEAD_BEEF, 6'd0, 2'd0, 32'hDEAD_BEEF);
    do_vec("lsl_31", 32'h0000_0003, 6'd31, 2'd0, 32'h8000_0000);
    do_vec("asr_4", 32'h8000_00F0, 6'd4, 2'd2, 32'hF800_000F);
    do_vec("asr_33", 32'h8000_00F0, 6'd33, 2'd2, 32'hFFFF_FFFF);
    do_vec("asr_32", 32'h8000_00F0, 6'd32, 2'd2, 32'hFFFF_FFFF);
    do_vec("asr_pos_4", 32'h7000_0000, 6'd4, 2'd2, 32'h0700_0000);
    do_vec("asr_pos_63", 32'h7FFF_FFFF, 6'd63, 2'd2, 32'h0000_0000);
    do_vec("lsr_4", 32'h8000_00F0, 6'd4, 2'd1, 32'h0800_000F);
    do_vec("lsr_33", 32'h8000_00F0, 6'd33, 2'd1, 32'h0000_0000);
    do_vec("rol_1", 32'h8000_0001, 6'd1, 2'd3, 32'h0000_0003);
    do_vec("rol_33", 32'h8000_0001, 6'd33, 2'd3, 32'h0000_0003);
    do_vec("rol_32", 32'h8000_0001, 6'd32, 2'd3, 32'h8000_0001);
    do_vec("rol_31", 32'h8000_0001, 6'd31, 2'd3, 32'hC000_0000);

    // 64-beat stream under random backpressure.
    for (int k = 0; k < 64; k++) begin
      rnd_d[k] = $urandom;
      rnd_s[k] = 6'($urandom_range(0, 63));
      rnd_m[k] = 2'($urandom_range(0, 3));
      rnd_u[k] = 2'($urandom_range(0, 3));
      rnd_l[k] = 1'($urandom_range(0, 1));
      rnd_e[k] = ref_shift(rnd_d[k], rnd_s[k], rnd_m[k]);
    end
    rcv = 0; stall_err = 0;
    fork
      begin
        for (int k = 0; k < 64; k++) push_beat(rnd_d[k], rnd_s[k], rnd_m[k], rnd_u[k], rnd_l[k]);
      end
      begin
        bit stall = 1'b0;
        logic [31:0] sd = '0; logic [1:0] su = '0; logic sl = 1'b0;
        for (int c = 0; c < 4000 && rcv < 64; c++) begin
          m_ready = 1'($urandom_range(0, 1));
          @(negedge aclk);
          if (stall && !(m_valid === 1'b1 && m_data === sd && m_user === su && m_last === sl))
            stall_err++;
          stall = m_valid && !m_ready;
          sd = m_data; su = m_user; sl = m_last;
          if (m_valid && m_ready) begin
            check("stream_data", m_data, rnd_e[rcv]);
            check("stream_user", 32'(m_user), 32'(rnd_u[rcv]));
            check("stream_last", 32'(m_last), 32'(rnd_l[rcv]));
            rcv++;
          end
          @(posedge aclk); #1;
        end
      end
    join
    m_ready = 1'b1;
    check("stream_count", 32'(rcv), 32'd64);
    check("stream_stable", 32'(stall_err), 32'd0);
    extra = 0;
    repeat (10) begin
      @(negedge aclk);
      if (m_valid) extra++;
      @(posedge aclk); #1;
    end
    check("stream_no_extra", 32'(extra), 32'd0);

    // Full-throughput run on all three pipeline depths.
    for (int k = 0; k < 100; k++)
      tp_e[k] = ref_shift(32'h1357_9BDF * 32'(k + 1), 6'(k), 2'(k));
    sent = 0; rcv1 = 0; rcv0 = 0; rcv3 = 0; done1 = -1; done0 = -1; done3 = -1;
    for (int e = 1; e <= 300 && (done1 < 0 || done0 < 0 || done3 < 0); e++) begin
      if (sent < 100) begin
        s_tdata = 32'h1357_9BDF * 32'(sent + 1); s_tshift = 6'(sent); s_tmode = 2'(sent);
        s_valid = 1'b1; a_valid = 1'b1;
      end else begin
        s_valid = 1'b0; a_valid = 1'b0;
      end
      @(negedge aclk);
      if (s_valid && s_ready) sent++;
      if (m_valid) begin
        if (rcv1 < 100) check("tp_l1", m_data, tp_e[rcv1]);
        rcv1++;
        if (rcv1 == 100) done1 = e;
      end
      if (mv0) begin
        if (rcv0 < 100) check("tp_l0", md0, tp_e[rcv0]);
        rcv0++;
        if (rcv0 == 100) done0 = e;
      end
      if (mv3) begin
        if (rcv3 < 100) check("tp_l3", md3, tp_e[rcv3]);
        rcv3++;
        if (rcv3 == 100) done3 = e;
      end
      @(posedge aclk); #1;
    end
    s_valid = 1'b0; a_valid = 1'b0;
    check("tp_cycles_l1", 32'(done1), 32'(100 + L1));
    check("tp_cycles_l0", 32'(done0), 32'(100 + L0));
    check("tp_cycles_l3", 32'(done3), 32'(100 + L3));
    check("tp_count_l1", 32'(rcv1), 32'd100);

    // Reset asserted with beats in flight.
    m_ready = 1'b0;
    push_beat(32'h0000_0011, 6'd1, 2'd0, 2'd1, 1'b0);
    push_beat(32'h0000_0022, 6'd2, 2'd1, 2'd2, 1'b0);
    push_beat(32'h0000_0033, 6'd3, 2'd2, 2'd3, 1'b0);
    push_beat(32'h0000_0044, 6'd4, 2'd3, 2'd0, 1'b1);
    repeat (8) @(posedge aclk);
    #1;
    check("inflight_valid", 32'(m_valid), 32'd1);
    @(negedge aclk);
    #1 aresetn = 1'b0;
    #1;
    check("midreset_m_valid", 32'(m_valid), 32'd0);
    check("midreset_s_ready", 32'(s_ready), 32'd0);
    check("midreset_m_data", m_data, 32'h0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    m_ready = 1'b1;
    stale = 0;
    repeat (20) begin
      @(negedge aclk);
      if (m_valid) stale++;
      @(posedge aclk); #1;
    end
    check("no_stale_beat", 32'(stale), 32'd0);
    push_beat(32'h0000_0005, 6'd3, 2'd0, 2'd0, 1'b0);
    pull_beat(vd, vu, vl, lat);
    check("post_reset_latency", 32'(lat), 32'(L1));
    check("post_reset_data", vd, 32'h0000_0028);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
